// File: rtl/am_env_meas.sv
// AM envelope and carrier measurement: windowed max/min/peak-to-peak/midpoint of
// offset-binary ADC samples plus rising midscale crossing count, with valid/ack results.
module am_env_meas #(
    parameter int WIN_LEN = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             adc_valid,
    input  logic [11:0]      adc_data,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ack,
    output logic [11:0]      vmax,
    output logic [11:0]      vmin,
    output logic [11:0]      vpp,
    output logic [11:0]      vmid,
    output logic [CNT_W-1:0] zc_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEAS = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [11:0]      MID_SCALE = 12'd2048;
    localparam logic [15:0]      WIN_FULL  = 16'(WIN_LEN);
    localparam logic [CNT_W-1:0] ZC_SAT    = {CNT_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [15:0]      scnt_r;
    logic [11:0]      run_max_r;
    logic [11:0]      run_min_r;
    logic [CNT_W-1:0] zc_r;
    logic             prev_vld_r;
    logic             prev_low_r;
    logic             busy_r;
    logic             res_valid_r;
    logic [11:0]      vmax_r;
    logic [11:0]      vmin_r;
    logic [11:0]      vpp_r;
    logic [11:0]      vmid_r;
    logic [CNT_W-1:0] zc_cnt_r;
    logic             start_s;
    logic             accept_s;
    logic             cross_s;

    // Acceptance, start qualification and rising-crossing detection
    always_comb begin
        start_s  = 1'b0;
        accept_s = 1'b0;
        cross_s  = 1'b0;
        if (state_r == ST_IDLE && start) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        // The window closes as soon as the final sample lands; the FSM leaves MEAS a cycle later.
        if (state_r == ST_MEAS && adc_valid && scnt_r != WIN_FULL) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (prev_vld_r && prev_low_r && adc_data >= MID_SCALE) begin
            cross_s = 1'b1;
        end else begin
            cross_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_MEAS;
                else       state_nxt_s = ST_IDLE;
            end
            ST_MEAS: begin
                if (scnt_r == WIN_FULL) state_nxt_s = ST_CALC;
                else                    state_nxt_s = ST_MEAS;
            end
            ST_CALC: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (res_ack) state_nxt_s = ST_IDLE;
                else         state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            res_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Running window statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_r     <= 16'd0;
            run_max_r  <= 12'd0;
            run_min_r  <= 12'd0;
            zc_r       <= {CNT_W{1'b0}};
            prev_vld_r <= 1'b0;
            prev_low_r <= 1'b0;
        end else if (start_s) begin
            scnt_r     <= 16'd0;
            run_max_r  <= 12'd0;
            run_min_r  <= 12'd0;
            zc_r       <= {CNT_W{1'b0}};
            prev_vld_r <= 1'b0;
            prev_low_r <= 1'b0;
        end else if (accept_s) begin
            scnt_r     <= scnt_r + 16'd1;
            prev_vld_r <= 1'b1;
            prev_low_r <= (adc_data < MID_SCALE);
            if (!prev_vld_r) begin
                run_max_r <= adc_data;
                run_min_r <= adc_data;
            end else begin
                if (adc_data > run_max_r) run_max_r <= adc_data;
                else                      run_max_r <= run_max_r;
                if (adc_data < run_min_r) run_min_r <= adc_data;
                else                      run_min_r <= run_min_r;
            end
            // Saturate rather than wrap so a huge window still reports a plausible ceiling.
            if (cross_s && zc_r != ZC_SAT) zc_r <= zc_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else                           zc_r <= zc_r;
        end else begin
            scnt_r     <= scnt_r;
            run_max_r  <= run_max_r;
            run_min_r  <= run_min_r;
            zc_r       <= zc_r;
            prev_vld_r <= prev_vld_r;
            prev_low_r <= prev_low_r;
        end
    end

    // Result registers, loaded only in CALC and held through DONE and beyond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vmax_r   <= 12'd0;
            vmin_r   <= 12'd0;
            vpp_r    <= 12'd0;
            vmid_r   <= 12'd0;
            zc_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_CALC) begin
            vmax_r   <= run_max_r;
            vmin_r   <= run_min_r;
            vpp_r    <= run_max_r - run_min_r;
            vmid_r   <= 12'(({1'b0, run_max_r} + {1'b0, run_min_r}) >> 1);
            zc_cnt_r <= zc_r;
        end else begin
            vmax_r   <= vmax_r;
            vmin_r   <= vmin_r;
            vpp_r    <= vpp_r;
            vmid_r   <= vmid_r;
            zc_cnt_r <= zc_cnt_r;
        end
    end

    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign vmax      = vmax_r;
    assign vmin      = vmin_r;
    assign vpp       = vpp_r;
    assign vmid      = vmid_r;
    assign zc_cnt    = zc_cnt_r;

endmodule

// File: tb/tb_am_env_meas.sv
// Directed plus randomized bench for am_env_meas (WIN_LEN=8) against a window-level model.
module tb_am_env_meas;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        busy;
    logic        res_valid;
    logic        res_ack;
    logic [11:0] vmax;
    logic [11:0] vmin;
    logic [11:0] vpp;
    logic [11:0] vmid;
    logic [15:0] zc_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] win [8];

    am_env_meas #(.WIN_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .adc_valid(adc_valid),
        .adc_data(adc_data), .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
        .vmax(vmax), .vmin(vmin), .vpp(vpp), .vmid(vmid), .zc_cnt(zc_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, ".vmax"}, 32'(vmax), 32'd0);
        chk({tag, ".vmin"}, 32'(vmin), 32'd0);
        chk({tag, ".vpp"}, 32'(vpp), 32'd0);
        chk({tag, ".vmid"}, 32'(vmid), 32'd0);
        chk({tag, ".zc_cnt"}, 32'(zc_cnt), 32'd0);
    endtask

    // Reference: plain arithmetic over the whole window.
    task automatic check_results(input string tag);
        int mx, mn, zc;
        mx = int'(win[0]);
        mn = int'(win[0]);
        zc = 0;
        for (int i = 1; i < 8; i++) begin
            if (int'(win[i]) > mx) mx = int'(win[i]);
            if (int'(win[i]) < mn) mn = int'(win[i]);
            if (int'(win[i-1]) < 2048 && int'(win[i]) >= 2048) zc++;
        end
        chk({tag, ".vmax"}, 32'(vmax), 32'(mx));
        chk({tag, ".vmin"}, 32'(vmin), 32'(mn));
        chk({tag, ".vpp"}, 32'(vpp), 32'(mx - mn));
        chk({tag, ".vmid"}, 32'(vmid), 32'((mx + mn) / 2));
        chk({tag, ".zc_cnt"}, 32'(zc_cnt), 32'(zc));
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    endtask

    // gap < 0 selects a random 0..2 cycle gap between samples.
    task automatic feed_window(input string tag, input int gap, input bit mid_start);
        int g;
        for (int i = 0; i < 8; i++) begin
            adc_data  = win[i];
            adc_valid = 1'b1;
            if (mid_start && i == 4) start = 1'b1;
            tick();
            adc_valid = 1'b0;
            start     = 1'b0;
            if (i < 7) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) tick();
            end
        end
        chk({tag, ".rv_s0"}, 32'(res_valid), 32'd0);
        tick();
        chk({tag, ".rv_s1"}, 32'(res_valid), 32'd0);
        chk({tag, ".busy_s1"}, 32'(busy), 32'd1);
        tick();
        chk({tag, ".rv_s2"}, 32'(res_valid), 32'd1);
        check_results(tag);
    endtask

    task automatic do_ack(input string tag);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk({tag, ".rv_after_ack"}, 32'(res_valid), 32'd0);
        chk({tag, ".busy_after_ack"}, 32'(busy), 32'd0);
    endtask

    task automatic rand_window();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) win[i] = 12'($urandom_range(0, 4095));
            else                           win[i] = 12'($urandom_range(2040, 2055));
        end
    endtask

    initial begin
        logic [11:0] old_max, old_min;
        rst_n     = 1'b0;
        start     = 1'b0;
        adc_valid = 1'b0;
        adc_data  = 12'd0;
        res_ack   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_zero("reset");
        adc_valid = 1'b1;
        adc_data  = 12'd3000;
        res_ack   = 1'b1;
        repeat (4) tick();
        adc_valid = 1'b0;
        res_ack   = 1'b0;
        tick();
        chk_zero("idle_noise");

        for (int i = 0; i < 8; i++) win[i] = 12'(100 + i);
        do_start("ramp");
        feed_window("ramp", 0, 1'b0);
        do_ack("ramp");

        for (int i = 0; i < 8; i++) win[i] = (i % 2 == 0) ? 12'd1000 : 12'd3000;
        do_start("square");
        feed_window("square", 0, 1'b0);
        do_ack("square");

        for (int i = 0; i < 8; i++) win[i] = (i % 2 == 0) ? 12'd0 : 12'd4095;
        do_start("extremes");
        feed_window("extremes", 0, 1'b0);
        do_ack("extremes");

        for (int i = 0; i < 8; i++) win[i] = (i % 2 == 0) ? 12'd1000 : 12'd3000;
        do_start("gapped");
        feed_window("gapped", 3, 1'b1);
        do_ack("gapped");

        win[0] = 12'd2047; win[1] = 12'd2048; win[2] = 12'd2047; win[3] = 12'd2048;
        win[4] = 12'd0;    win[5] = 12'd2048; win[6] = 12'd4095; win[7] = 12'd2047;
        do_start("midscale");
        feed_window("midscale", 1, 1'b0);
        do_ack("midscale");

        rand_window();
        do_start("hs");
        feed_window("hs", -1, 1'b0);
        old_max = vmax;
        old_min = vmin;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) start = 1'b1;
            tick();
            start = 1'b0;
            chk("hs.rv_held", 32'(res_valid), 32'd1);
            check_results("hs.held");
        end
        start   = 1'b1;
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        start   = 1'b0;
        chk("hs.busy_simul", 32'(busy), 32'd0);
        chk("hs.rv_simul", 32'(res_valid), 32'd0);
        tick();
        chk("hs.busy_idle", 32'(busy), 32'd0);
        do_start("hs.restart");
        chk("hs.vmax_kept", 32'(vmax), 32'(old_max));
        chk("hs.vmin_kept", 32'(vmin), 32'(old_min));
        rand_window();
        feed_window("hs.next", 0, 1'b0);
        do_ack("hs.next");

        rand_window();
        do_start("rst_mid");
        for (int i = 0; i < 5; i++) begin
            adc_data  = win[i];
            adc_valid = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_zero("rst_mid.async");
        tick();
        rst_n = 1'b1;
        tick();
        chk_zero("rst_mid.after");
        rand_window();
        do_start("rst_mid.fresh");
        feed_window("rst_mid.fresh", -1, 1'b0);
        do_ack("rst_mid.fresh");

        for (int r = 0; r < 6; r++) begin
            rand_window();
            do_start("rand");
            feed_window("rand", -1, ($urandom_range(0, 1) == 1));
            do_ack("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/am_env_meas.md
# am_env_meas

AM envelope and carrier measurement block on the receive/loop-back side of the DDS AM generator. It accepts 12-bit offset-binary ADC samples of the AM waveform produced by the DAC path. Over a fixed window of samples it measures the envelope extremes (max/min), peak-to-peak, midpoint and the count of rising midscale crossings. The carrier frequency is derived from the crossing count. Results go to the control logic through a valid/ack handshake.

## Interface
Parameters:
- WIN_LEN, 4096: samples per measurement window; legal range 2..65535.
- CNT_W, 16: width of the crossing counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse that begins a measurement; honoured only in IDLE.
- adc_valid  in  1  sample strobe; adc_data is accepted on a cycle where adc_valid=1 and state is MEAS.
- adc_data  in  12  offset-binary sample; midscale is 2048.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result-available flag; held high until acknowledged.
- res_ack  in  1  consumer acknowledge; effective only while res_valid=1.
- vmax  out  12  maximum sample in the window.
- vmin  out  12  minimum sample in the window.
- vpp  out  12  vmax − vmin.
- vmid  out  12  (vmax + vmin) >> 1, computed with a 13-bit intermediate sum.
- zc_cnt  out  CNT_W  count of rising midscale crossings in the window.

## Operation
- States and transitions:
  - IDLE → MEAS on start.
  - MEAS → CALC on the accepted sample that makes the count equal WIN_LEN.
  - CALC → DONE unconditionally.
  - DONE → IDLE on res_ack.
- Entering MEAS clears:
  - the sample counter,
  - the internal running max/min,
  - the internal crossing count,
  - the previous-sample-valid flag.
- First accepted sample: loads both running max and running min.
- Later samples:
  - max updates when sample > max;
  - min updates when sample < min.
- Rising crossing: the previous accepted sample is < 2048 and the current accepted sample is ≥ 2048. The first sample of the window never counts.
- The crossing count saturates at 2^CNT_W − 1; it does not wrap.
- Samples presented while not in MEAS are ignored.
- CALC:
  - registers vmax, vmin, vpp, vmid and zc_cnt from the running values;
  - the output registers change only here.
- DONE:
  - res_valid=1;
  - outputs are stable until the next CALC, including after the ack.
- start outside IDLE is ignored. This covers MEAS, CALC and DONE.
- res_ack outside DONE is ignored.
- If start and res_ack are both high in DONE, the block goes to IDLE only. That start is not honoured.
- Reset at any time:
  - returns to IDLE;
  - all outputs are 0 (busy, res_valid, vmax, vmin, vpp, vmid, zc_cnt);
  - internal counters are 0.

## Timing
- start sampled at edge t → busy=1 after edge t; the first sample can be accepted at edge t+1.
- Last window sample accepted at edge s:
  - CALC is active during cycle s+1;
  - result registers and res_valid=1 are updated at edge s+2.
- res_ack sampled at edge a → res_valid=0 and busy=0 after edge a. A new start is accepted at edge a+1 at the earliest.
- Minimum measurement duration is WIN_LEN accepted samples. adc_valid may have arbitrary gaps, and the block has no timeout.
- Throughput is one sample per clock when adc_valid is held high.

## Test plan
All scenarios use WIN_LEN=8, CNT_W=16.
1. Reset:
   - Stimulus: rst_n low, released.
   - Required response: busy=0, res_valid=0, vmax=vmin=vpp=vmid=0, zc_cnt=0; adc_valid activity without start causes no state change.
2. Ramp:
   - Stimulus: start, then samples 100..107 with back-to-back adc_valid.
   - Required response: vmax=107, vmin=100, vpp=7, vmid=103, zc_cnt=0; res_valid rises 2 cycles after the 8th sample.
3. Square AM:
   - Stimulus: samples 1000,3000,1000,3000,1000,3000,1000,3000.
   - Required response: vmax=3000, vmin=1000, vpp=2000, vmid=2000, zc_cnt=4.
   - Extremes follow-up — stimulus: a window of 0,4095,0,4095,0,4095,0,4095.
   - Required response: vpp=4095, vmid=2047, zc_cnt=4.
4. Gapped valid:
   - Stimulus: repeat scenario 3 with adc_valid low for 3 cycles between samples, and start pulsed mid-window.
   - Required response: identical results; the extra start is ignored.
5. Handshake:
   - Stimulus: withhold res_ack for 10 cycles, pulse start during that time, then assert start and res_ack together, then start one cycle later.
   - Required response: res_valid stays 1 and outputs stay stable while ack is withheld; the block goes to IDLE, with the simultaneous start ignored; the following start gives busy=1 while vmax/vmin keep their old values.
6. Reset mid-measurement:
   - Stimulus: assert rst_n low after 5 samples.
   - Required response: all outputs 0, state IDLE; a new full window yields correct fresh results.
